busy_control_mc: RTL
====================

BUSY_CONTROL_MC -- requirements
Module: busy_control_mc

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of readout channels tracked.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the trigger and read counters.
REQ-003 The block SHALL have parameter DEPTH, default 32, meaning the event-buffer depth per channel; OCC_W = clog2(DEPTH)+1.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-006 The block SHALL have port live_rising, input, 1, a synchronous run-start clear.
REQ-007 The block SHALL have port trig, input, 1, the trigger level; a 0->1 transition is one trigger request.
REQ-008 The block SHALL have port n_read, input, N_CH*CNT_W, the per-channel events-read counts; channel i is at bits [i*CNT_W +: CNT_W].
REQ-009 The block SHALL have port ch_en, input, N_CH, the channel enable mask.
REQ-010 The block SHALL have ports busy_on and busy_off, input, OCC_W each, the assert and release thresholds.
REQ-011 The block SHALL have outputs busy (1), trig_acc (1), n_trig (CNT_W), max_occ (OCC_W), read_overflow (N_CH), state (2).

Function
REQ-012 The block SHALL register trig into trig_d; trig_req = trig & ~trig_d.
REQ-013 trig_acc SHALL equal trig_req & (state==READY) combinationally; when asserted, n_trig increments by 1 at the next edge, wrapping modulo 2^CNT_W.
REQ-014 Per enabled channel, occ_i SHALL be (n_trig - n_read_i) mod 2^CNT_W, using registered n_trig.
REQ-015 overflow_i SHALL be occ_i > DEPTH, which also covers read-ahead-of-trigger via wrap; read_overflow[i] is sticky, set one cycle later.
REQ-016 max_occ SHALL be the registered maximum of occ_i over enabled channels; it is 0 when ch_en==0.
REQ-017 Disabled channels SHALL be excluded from max_occ and overflow; their read_overflow bit holds its value.
REQ-018 The FSM SHALL have the states IDLE=0, READY=1, BUSY=2 and FAULT=3.
REQ-019 On live_rising, the block SHALL go from any state to READY and clear n_trig, trig_d, max_occ, read_overflow and stats in the same edge; a coincident trig_req is dropped.
REQ-020 In READY, the block SHALL go to BUSY when max_occ >= busy_on.
REQ-021 In BUSY, the block SHALL go to READY when max_occ <= eff_off, where eff_off = min(busy_off, busy_on-1); if busy_on==0, BUSY never releases.
REQ-022 In READY or BUSY, the block SHALL go to FAULT when any enabled overflow_i is set, with priority over REQ-020/021; FAULT is left only via live_rising or rst.
REQ-023 busy SHALL be a registered output, 1 whenever next state != READY; trig edge to busy latency is 3 edges (n_trig, max_occ, busy).
REQ-024 busy_on SHALL be set by software to at most DEPTH-3 to absorb the 3-cycle latency; the block does not clamp it.

Reset
REQ-025 On rst, the block SHALL take state=IDLE, busy=1, trig_acc=0, n_trig=0, max_occ=0, read_overflow=0, trig_d=0 and stat counters 0, asynchronously.
REQ-026 In IDLE, the block SHALL hold busy=1 and ignore trig until the first live_rising.

Configuration
REQ-027 With BUSY_STAT_EN defined, the block SHALL add outputs busy_cycles (32) and n_veto (CNT_W); busy_cycles counts cycles with busy=1 in BUSY or FAULT, and n_veto counts trig_req with trig_acc=0 outside IDLE; both saturate at all-ones and are cleared by rst and live_rising.
REQ-028 Without BUSY_STAT_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-029 Package busy_pkg SHALL hold the state enum (IDLE/READY/BUSY/FAULT) and the default constants for N_CH, CNT_W and DEPTH.
REQ-030 Sub-module busy_occ_ch SHALL compute occ_i and overflow_i for one channel and be instantiated N_CH times by generate; the FSM, max tree and stats stay in busy_control_mc.

Verification
REQ-031 Scenario: rst, then live_rising, then 30 trig pulses with no reads and busy_on=30, busy_off=28 -> busy=1 three edges after the 30th edge; a 31st pulse gives trig_acc=0.
REQ-032 Scenario: continuing REQ-031, raise every n_read to 1 then 2 -> busy stays 1 at occ=29; busy=0 at occ=28; the next trig is accepted.
REQ-033 Scenario: n_trig=5 with ch1 n_read=6 -> read_overflow[1]=1, state=FAULT, busy=1; with ch_en[1]=0 the same stimulus gives no fault.
REQ-034 Scenario: preload n_trig=0xFFFE with n_read=0xFFFE, then 4 trig pulses -> n_trig=0x0002, max_occ=4, no overflow.
REQ-035 Scenario: live_rising coincident with a trig edge while in FAULT -> READY, n_trig=0, read_overflow=0, the trig is not counted.
REQ-036 Scenario: with BUSY_STAT_EN, 5 trig edges while BUSY -> n_veto=5; busy_cycles equals the BUSY cycle count.

Source files
------------

// File: rtl/busy_control_mc_pkg.sv
// -----------------------------------------------------------------------------
// busy_pkg
// Shared definitions for the multi-channel busy controller:
//   - state_t        : FSM state encoding (IDLE/READY/BUSY/FAULT)
//   - *_DEF          : default values for the N_CH, CNT_W and DEPTH parameters
// -----------------------------------------------------------------------------
package busy_pkg;

    localparam int BUSY_N_CH_DEF  = 4;
    localparam int BUSY_CNT_W_DEF = 16;
    localparam int BUSY_DEPTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        BUSY  = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/busy_control_mc_occ_ch.sv
// -----------------------------------------------------------------------------
// busy_occ_ch
// Occupancy of one readout channel's event buffer, derived from the accepted
// trigger count and the channel's events-read count.
//
// Ports:
//   i_n_trig   [CNT_W] registered accepted-trigger count
//   i_n_read   [CNT_W] events read by this channel
//   o_occ      [OCC_W] occupancy, clamped to DEPTH+1 when overflowing
//   o_overflow [1]     occupancy exceeds DEPTH (includes read-ahead via wrap)
// -----------------------------------------------------------------------------
module busy_occ_ch #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 32,
    parameter int OCC_W = 6
) (
    input  logic [CNT_W-1:0] i_n_trig,
    input  logic [CNT_W-1:0] i_n_read,
    output logic [OCC_W-1:0] o_occ,
    output logic             o_overflow
);

    logic [CNT_W-1:0] w_occ_raw;

    // Modular difference: a read count ahead of the trigger count wraps to a
    // huge value and is therefore caught by the same overflow compare.
    assign w_occ_raw  = i_n_trig - i_n_read;
    assign o_overflow = (w_occ_raw > CNT_W'(DEPTH));

    // An overflowing occupancy does not fit OCC_W; DEPTH+1 always does and
    // still compares above any legal threshold.
    assign o_occ = o_overflow ? OCC_W'(DEPTH + 1) : w_occ_raw[OCC_W-1:0];

endmodule

// File: rtl/busy_control_mc.sv
// -----------------------------------------------------------------------------
// busy_control_mc
// Trigger busy/veto controller tracking per-channel event-buffer occupancy.
// Accepts trigger edges while READY, raises busy when the fullest enabled
// channel reaches busy_on, releases at the effective busy_off threshold, and
// latches FAULT on any enabled channel overflow.
//
// Optional feature macro: BUSY_STAT_EN (adds busy_cycles / n_veto counters).
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   live_rising    synchronous run-start clear (forces READY)
//   trig           trigger level; each 0->1 is one request
//   n_read         per-channel events-read counts, channel i at [i*CNT_W +: CNT_W]
//   ch_en          channel enable mask
//   busy_on        busy assert threshold
//   busy_off       busy release threshold
//   busy           registered busy output
//   trig_acc       trigger accepted this cycle (combinational)
//   n_trig         accepted trigger count
//   max_occ        registered max occupancy over enabled channels
//   read_overflow  sticky per-channel overflow flags
//   state          FSM state
//   busy_cycles    (BUSY_STAT_EN) cycles spent busy in BUSY or FAULT
//   n_veto         (BUSY_STAT_EN) trigger requests refused outside IDLE
//
// state | meaning
// IDLE  | after reset, waiting for first live_rising; busy held, trig ignored
// READY | accepting triggers
// BUSY  | buffers near full; triggers vetoed until occupancy drains
// FAULT | a channel overflowed; left only by live_rising or rst
// -----------------------------------------------------------------------------
module busy_control_mc
    import busy_pkg::*;
#(
    parameter  int N_CH  = BUSY_N_CH_DEF,
    parameter  int CNT_W = BUSY_CNT_W_DEF,
    parameter  int DEPTH = BUSY_DEPTH_DEF,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  live_rising,
    input  logic                  trig,
    input  logic [N_CH*CNT_W-1:0] n_read,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [OCC_W-1:0]      busy_on,
    input  logic [OCC_W-1:0]      busy_off,
    output logic                  busy,
    output logic                  trig_acc,
    output logic [CNT_W-1:0]      n_trig,
    output logic [OCC_W-1:0]      max_occ,
    output logic [N_CH-1:0]       read_overflow,
    output logic [1:0]            state
`ifdef BUSY_STAT_EN
    ,
    output logic [31:0]           busy_cycles,
    output logic [CNT_W-1:0]      n_veto
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_trig_d;
    logic [CNT_W-1:0] r_n_trig;
    logic [OCC_W-1:0] r_max;
    logic [N_CH-1:0]  r_rd_ovf;

    logic             w_trig_req;
    logic             w_trig_acc;
    logic [OCC_W-1:0] w_occ [N_CH];
    logic [N_CH-1:0]  w_ovf;
    logic             w_any_ovf;
    logic [OCC_W-1:0] w_max;
    logic [OCC_W-1:0] w_eff_off;

    assign w_trig_req = trig & ~r_trig_d;
    assign w_trig_acc = w_trig_req & (r_state == READY);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        busy_occ_ch #(
            .CNT_W (CNT_W),
            .DEPTH (DEPTH),
            .OCC_W (OCC_W)
        ) u_occ (
            .i_n_trig   (r_n_trig),
            .i_n_read   (n_read[g*CNT_W +: CNT_W]),
            .o_occ      (w_occ[g]),
            .o_overflow (w_ovf[g])
        );
    end

    assign w_any_ovf = |(w_ovf & ch_en);

    always_comb begin
        w_max = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_en[i] && (w_occ[i] > w_max)) begin
                w_max = w_occ[i];
            end
        end
    end

    // Release threshold kept strictly below busy_on so the FSM cannot
    // oscillate; busy_on==0 is handled separately (never releases).
    assign w_eff_off = (busy_off < busy_on) ? busy_off : (busy_on - OCC_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        if (live_rising) begin
            w_state_nxt = READY;
        end else begin
            case (r_state)
                IDLE:  w_state_nxt = IDLE;
                READY: begin
                    if (w_any_ovf) begin
                        w_state_nxt = FAULT;
                    end else if (r_max >= busy_on) begin
                        w_state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (w_any_ovf) begin
                        w_state_nxt = FAULT;
                    end else if ((busy_on != '0) && (r_max <= w_eff_off)) begin
                        w_state_nxt = READY;
                    end
                end
                FAULT: w_state_nxt = FAULT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_busy   <= 1'b1;
            r_trig_d <= 1'b0;
            r_n_trig <= '0;
            r_max    <= '0;
            r_rd_ovf <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != READY);
            if (live_rising) begin
                // A coincident trigger edge is dropped: the count is cleared.
                r_trig_d <= 1'b0;
                r_n_trig <= '0;
                r_max    <= '0;
                r_rd_ovf <= '0;
            end else begin
                r_trig_d <= trig;
                if (w_trig_acc) begin
                    r_n_trig <= r_n_trig + CNT_W'(1);
                end
                r_max    <= w_max;
                r_rd_ovf <= r_rd_ovf | (w_ovf & ch_en);
            end
        end
    end

`ifdef BUSY_STAT_EN
    logic [31:0]      r_busy_cycles;
    logic [CNT_W-1:0] r_n_veto;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cycles <= '0;
            r_n_veto      <= '0;
        end else if (live_rising) begin
            r_busy_cycles <= '0;
            r_n_veto      <= '0;
        end else begin
            if (r_busy && ((r_state == BUSY) || (r_state == FAULT)) &&
                (r_busy_cycles != '1)) begin
                r_busy_cycles <= r_busy_cycles + 32'd1;
            end
            if (w_trig_req && !w_trig_acc && (r_state != IDLE) &&
                (r_n_veto != '1)) begin
                r_n_veto <= r_n_veto + CNT_W'(1);
            end
        end
    end

    assign busy_cycles = r_busy_cycles;
    assign n_veto      = r_n_veto;
`endif

    assign busy          = r_busy;
    assign trig_acc      = w_trig_acc;
    assign n_trig        = r_n_trig;
    assign max_occ       = r_max;
    assign read_overflow = r_rd_ovf;
    assign state         = r_state;

endmodule
